// File: rtl/uart_cmd_frame_decode.sv
// Command frame decoder between the UART receiver and the SDRAM write/read controllers.
// Optional inter-byte payload timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_frame_decode #(
    parameter int                DATA_W      = 8,
    parameter int                BURST_LEN   = 4,
    parameter logic [DATA_W-1:0] WR_CMD      = 8'h55,
    parameter logic [DATA_W-1:0] RD_CMD      = 8'hAA,
    parameter int                TIMEOUT_CYC = 50000
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              uart_flag,
    input  logic [DATA_W-1:0] uart_data,
    input  logic              wfifo_full,
    output logic              wfifo_wr_en,
    output logic [DATA_W-1:0] wfifo_data,
    output logic              wfifo_clr,
    output logic              wr_trig,
    output logic              rd_trig,
    output logic              cmd_err,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("uart_cmd_frame_decode: BURST_LEN must be 1..256");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_cmd_frame_decode: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wfifo_wr_en_q, wfifo_wr_en_d;
    logic [DATA_W-1:0] wfifo_data_q, wfifo_data_d;
    logic              wfifo_clr_q, wfifo_clr_d;
    logic              wr_trig_q, wr_trig_d;
    logic              rd_trig_q, rd_trig_d;
    logic              cmd_err_q, cmd_err_d;
    logic              frame_err_q, frame_err_d;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wfifo_wr_en_d = 1'b0;
        wfifo_data_d  = wfifo_data_q;
        wfifo_clr_d   = 1'b0;
        wr_trig_d     = 1'b0;
        rd_trig_d     = 1'b0;
        cmd_err_d     = 1'b0;
        frame_err_d   = 1'b0;
`ifdef CMD_TIMEOUT_EN
        // Zero unless idling in WR_DATA, so entry and every byte restart the count.
        idle_cnt_d    = '0;
`endif
        case (state_q)
            IDLE, WR_DONE: begin
                wr_trig_d = (state_q == WR_DONE);
                state_d   = IDLE;
                if (uart_flag) begin
                    if (uart_data == WR_CMD) begin
                        state_d = WR_DATA;
                        cnt_d   = '0;
                    end else if (uart_data == RD_CMD) begin
                        rd_trig_d = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                if (uart_flag) begin
                    if (!wfifo_full) begin
                        wfifo_wr_en_d = 1'b1;
                        wfifo_data_d  = uart_data;
                        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                            state_d = WR_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        wfifo_clr_d = 1'b1;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end else begin
`ifdef CMD_TIMEOUT_EN
                    if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        wfifo_clr_d = 1'b1;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TO_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wfifo_wr_en_q <= 1'b0;
            wfifo_data_q  <= '0;
            wfifo_clr_q   <= 1'b0;
            wr_trig_q     <= 1'b0;
            rd_trig_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wfifo_wr_en_q <= wfifo_wr_en_d;
            wfifo_data_q  <= wfifo_data_d;
            wfifo_clr_q   <= wfifo_clr_d;
            wr_trig_q     <= wr_trig_d;
            rd_trig_q     <= rd_trig_d;
            cmd_err_q     <= cmd_err_d;
            frame_err_q   <= frame_err_d;
`ifdef CMD_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign wfifo_wr_en = wfifo_wr_en_q;
    assign wfifo_data  = wfifo_data_q;
    assign wfifo_clr   = wfifo_clr_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_err     = cmd_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_frame_decode.sv
// Directed bench for uart_cmd_frame_decode (BURST_LEN=4, TIMEOUT_CYC=100).
module tb_uart_cmd_frame_decode;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       uart_flag = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       wfifo_full = 1'b0;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wfifo_clr;
    logic       wr_trig;
    logic       rd_trig;
    logic       cmd_err;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    int         n_wr, n_rd, n_cmd, n_fe, n_clr;
    logic [7:0] pushes[$];

    uart_cmd_frame_decode #(
        .DATA_W(8), .BURST_LEN(4), .WR_CMD(8'h55), .RD_CMD(8'hAA), .TIMEOUT_CYC(100)
    ) dut (
        .sclk(sclk), .s_rst(s_rst), .uart_flag(uart_flag), .uart_data(uart_data),
        .wfifo_full(wfifo_full), .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data),
        .wfifo_clr(wfifo_clr), .wr_trig(wr_trig), .rd_trig(rd_trig),
        .cmd_err(cmd_err), .frame_err(frame_err)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (wfifo_wr_en) pushes.push_back(wfifo_data);
        if (wr_trig)   n_wr++;
        if (rd_trig)   n_rd++;
        if (cmd_err)   n_cmd++;
        if (frame_err) n_fe++;
        if (wfifo_clr) n_clr++;
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        uart_data = b;
        uart_flag = 1'b1;
        tick();
        uart_flag = 1'b0;
    endtask

    task automatic clear_obs();
        @(posedge sclk);
        #1;
        n_wr = 0; n_rd = 0; n_cmd = 0; n_fe = 0; n_clr = 0;
        pushes.delete();
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        tick();
        tick();
        total++;
        if ({wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, cmd_err, frame_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_pulses got=%b want=000000",
                     {wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, cmd_err, frame_err});
        end
        total++;
        if (wfifo_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h want=00", wfifo_data);
        end
        s_rst = 1'b0;
        tick();
    endtask

    task automatic test_full_write();
        logic [7:0] exp_d[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        clear_obs();
        send(8'h55);
        total++;
        if (wfifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL fw_opcode_push got=%b want=0", wfifo_wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            repeat (20) tick();
            send(exp_d[i]);
            total++;
            if (wfifo_wr_en !== 1'b1 || wfifo_data !== exp_d[i] || wr_trig !== 1'b0) begin
                bad++;
                $display("FAIL fw_push%0d got en=%b data=%h trig=%b want en=1 data=%h trig=0",
                         i, wfifo_wr_en, wfifo_data, wr_trig, exp_d[i]);
            end
        end
        tick();
        total++;
        if (wr_trig !== 1'b1 || wfifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL fw_wr_trig got trig=%b en=%b want trig=1 en=0", wr_trig, wfifo_wr_en);
        end
        tick();
        total++;
        if (wr_trig !== 1'b0) begin
            bad++;
            $display("FAIL fw_wr_trig_len got=%b want=0", wr_trig);
        end
        repeat (3) tick();
        total++;
        if (pushes.size() != 4 || n_wr != 1 || n_rd != 0 || n_cmd != 0 || n_fe != 0) begin
            bad++;
            $display("FAIL fw_counts got push=%0d wr=%0d rd=%0d cmd=%0d fe=%0d want 4 1 0 0 0",
                     pushes.size(), n_wr, n_rd, n_cmd, n_fe);
        end
    endtask

    task automatic test_read_bad();
        clear_obs();
        send(8'hAA);
        total++;
        if (rd_trig !== 1'b1 || cmd_err !== 1'b0) begin
            bad++;
            $display("FAIL rd_trig got rd=%b cmd=%b want rd=1 cmd=0", rd_trig, cmd_err);
        end
        send(8'h3C);
        total++;
        if (cmd_err !== 1'b1 || rd_trig !== 1'b0) begin
            bad++;
            $display("FAIL cmd_err got cmd=%b rd=%b want cmd=1 rd=0", cmd_err, rd_trig);
        end
        repeat (3) tick();
        total++;
        if (pushes.size() != 0 || n_rd != 1 || n_cmd != 1 || n_fe != 0) begin
            bad++;
            $display("FAIL rb_counts got push=%0d rd=%0d cmd=%0d fe=%0d want 0 1 1 0",
                     pushes.size(), n_rd, n_cmd, n_fe);
        end
    endtask

    task automatic test_back_to_back_opcodes();
        clear_obs();
        send(8'h55);
        send(8'hAA);
        send(8'h55);
        send(8'hAA);
        send(8'h55);
        total++;
        if (wfifo_wr_en !== 1'b1 || wfifo_data !== 8'h55) begin
            bad++;
            $display("FAIL op_last_push got en=%b data=%h want en=1 data=55", wfifo_wr_en, wfifo_data);
        end
        tick();
        total++;
        if (wr_trig !== 1'b1) begin
            bad++;
            $display("FAIL op_wr_trig got=%b want=1", wr_trig);
        end
        repeat (3) tick();
        total++;
        if (pushes.size() != 4 || n_rd != 0 || n_cmd != 0 || n_wr != 1) begin
            bad++;
            $display("FAIL op_counts got push=%0d rd=%0d cmd=%0d wr=%0d want 4 0 0 1",
                     pushes.size(), n_rd, n_cmd, n_wr);
        end else begin
            total++;
            if (pushes[0] !== 8'hAA || pushes[1] !== 8'h55 || pushes[2] !== 8'hAA || pushes[3] !== 8'h55) begin
                bad++;
                $display("FAIL op_data got=%h %h %h %h want=aa 55 aa 55",
                         pushes[0], pushes[1], pushes[2], pushes[3]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_obs();
        send(8'h55);
        send(8'h01);
        send(8'h02);
        wfifo_full = 1'b1;
        send(8'h03);
        total++;
        if (wfifo_wr_en !== 1'b0 || wfifo_clr !== 1'b1 || frame_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_abort got en=%b clr=%b fe=%b want en=0 clr=1 fe=1",
                     wfifo_wr_en, wfifo_clr, frame_err);
        end
        wfifo_full = 1'b0;
        tick();
        total++;
        if (wfifo_clr !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_pulse_len got clr=%b fe=%b want 0 0", wfifo_clr, frame_err);
        end
        send(8'hAA);
        total++;
        if (rd_trig !== 1'b1 || wfifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL ovf_then_rd got rd=%b en=%b want rd=1 en=0", rd_trig, wfifo_wr_en);
        end
        repeat (3) tick();
        total++;
        if (pushes.size() != 2 || n_fe != 1 || n_clr != 1 || n_wr != 0) begin
            bad++;
            $display("FAIL ovf_counts got push=%0d fe=%0d clr=%0d wr=%0d want 2 1 1 0",
                     pushes.size(), n_fe, n_clr, n_wr);
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        clear_obs();
        send(8'h55);
        send(8'h01);
        early = 0;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (frame_err !== 1'b0 || wfifo_clr !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL to_early got=%0d early cycles want=0", early);
        end
        tick();
        total++;
        if (frame_err !== 1'b1 || wfifo_clr !== 1'b1) begin
            bad++;
            $display("FAIL to_expire got fe=%b clr=%b want 1 1", frame_err, wfifo_clr);
        end
        send(8'h3C);
        total++;
        if (cmd_err !== 1'b1) begin
            bad++;
            $display("FAIL to_back_idle got cmd=%b want=1", cmd_err);
        end

        clear_obs();
        send(8'h55);
        send(8'h01);
        repeat (99) tick();
        send(8'h02);
        total++;
        if (wfifo_wr_en !== 1'b1 || frame_err !== 1'b0 || wfifo_clr !== 1'b0) begin
            bad++;
            $display("FAIL to_byte_wins got en=%b fe=%b clr=%b want 1 0 0", wfifo_wr_en, frame_err, wfifo_clr);
        end
        send(8'h03);
        send(8'h04);
        tick();
        total++;
        if (wr_trig !== 1'b1 || n_fe != 0) begin
            bad++;
            $display("FAIL to_frame_done got trig=%b fe=%0d want trig=1 fe=0", wr_trig, n_fe);
        end
    endtask
`else
    task automatic test_no_timeout();
        clear_obs();
        send(8'h55);
        send(8'h01);
        repeat (200) tick();
        total++;
        if (n_fe != 0 || n_clr != 0) begin
            bad++;
            $display("FAIL nto_abort got fe=%0d clr=%0d want 0 0", n_fe, n_clr);
        end
        send(8'h02);
        send(8'h03);
        send(8'h04);
        tick();
        total++;
        if (wr_trig !== 1'b1 || pushes.size() != 4) begin
            bad++;
            $display("FAIL nto_frame_done got trig=%b push=%0d want trig=1 push=4", wr_trig, pushes.size());
        end
    endtask
`endif

    task automatic test_reset_midframe();
        clear_obs();
        send(8'h55);
        send(8'h01);
        s_rst = 1'b1;
        tick();
        total++;
        if ({wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, cmd_err, frame_err} !== 6'b0 || wfifo_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b data=%h want=000000 data=00",
                     {wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, cmd_err, frame_err}, wfifo_data);
        end
        s_rst = 1'b0;
        send(8'h02);
        total++;
        if (cmd_err !== 1'b1 || wfifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_decode got cmd=%b en=%b want cmd=1 en=0", cmd_err, wfifo_wr_en);
        end
        repeat (3) tick();
        total++;
        if (n_clr != 0 || pushes.size() != 1) begin
            bad++;
            $display("FAIL rst_mid_counts got clr=%0d push=%0d want 0 1", n_clr, pushes.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_read_bad();
        test_back_to_back_opcodes();
        test_overflow();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_decode.md
# uart_cmd_frame_decode

Parametrised successor to the fixed-format command decoder between the UART receiver and the SDRAM write/read controllers. It parses the received byte stream into command frames: a write command followed by a configurable number of payload bytes, or a single-byte read command. Payload bytes are pushed into the write FIFO, and a trigger pulse is issued to the SDRAM controller. It adds FIFO-full protection, frame abort with FIFO clear, and an optional inter-byte timeout.

## Interface
Parameters:
- DATA_W, 8: UART byte width.
- BURST_LEN, 4: payload bytes per write frame; legal range 1..256.
- WR_CMD, 8'h55: write command opcode.
- RD_CMD, 8'hAA: read command opcode.
- TIMEOUT_CYC, 50000: idle sclk cycles allowed between payload bytes. Used only with CMD_TIMEOUT_EN.

Ports:
- sclk, in, 1: system clock. All logic is on the rising edge.
- s_rst, in, 1: synchronous, active-high reset.
- uart_flag, in, 1: byte-valid strobe. Every high cycle counts as one byte.
- uart_data, in, DATA_W: received byte; valid when uart_flag=1.
- wfifo_full, in, 1: write FIFO full.
- wfifo_wr_en, out, 1: write FIFO push strobe.
- wfifo_data, out, DATA_W: payload byte to push.
- wfifo_clr, out, 1: one-cycle pulse; discard partial frame in FIFO.
- wr_trig, out, 1: one-cycle pulse; complete write frame is in the FIFO.
- rd_trig, out, 1: one-cycle pulse; read requested.
- cmd_err, out, 1: one-cycle pulse; unknown opcode in IDLE.
- frame_err, out, 1: one-cycle pulse; write frame aborted (overflow or timeout).

## Operation
- States: IDLE, WR_DATA, WR_DONE.
- IDLE, uart_flag with WR_CMD: go to WR_DATA, set cnt=0.
- IDLE, uart_flag with RD_CMD: rd_trig=1 next cycle; stay in IDLE.
- IDLE, uart_flag with any other byte: cmd_err=1 next cycle; stay in IDLE.
- WR_DATA, uart_flag with wfifo_full=0: push the byte (wfifo_wr_en=1, wfifo_data=uart_data next cycle) and increment cnt. When the byte is number BURST_LEN (cnt==BURST_LEN-1), go to WR_DATA's exit state WR_DONE.
- WR_DATA bytes are never decoded as opcodes. WR_CMD and RD_CMD values are payload here.
- WR_DATA, uart_flag with wfifo_full=1: byte is dropped, no push. Next cycle wfifo_clr=1 and frame_err=1; go to IDLE.
- WR_DONE: wr_trig=1 for one cycle; go to IDLE. A uart_flag in WR_DONE is decoded as in IDLE. Its outputs may coincide with wr_trig.
- cnt width is $clog2(BURST_LEN+1). cnt never exceeds BURST_LEN-1 and never wraps.
- Only one of rd_trig, cmd_err or frame_err asserts per accepted byte.

## Timing
- All outputs are registered. Reset value of every output is 0, and wfifo_data resets to 0.
- Reset: state returns to IDLE and cnt clears. A reset mid-frame does not produce wfifo_clr; the FIFO owner resets in parallel.
- Byte-to-output latency is 1 cycle: wfifo_wr_en, rd_trig, cmd_err, frame_err and wfifo_clr assert in the cycle after the sampled uart_flag.
- wr_trig asserts 1 cycle after the last wfifo_wr_en, which is 2 cycles after the last uart_flag.
- Back-to-back uart_flag on consecutive cycles is supported. Each high cycle is one byte.
- wfifo_full is sampled in the same cycle as uart_flag.

## Configuration
- CMD_TIMEOUT_EN defined:
  - An idle counter runs in WR_DATA. It resets on every uart_flag and on entry to WR_DATA.
  - When the counter reaches TIMEOUT_CYC-1 with no uart_flag, the next cycle gives wfifo_clr=1 and frame_err=1, and the state goes to IDLE.
  - If uart_flag arrives in the expiry cycle, the byte wins and no abort occurs.
- CMD_TIMEOUT_EN undefined: no counter exists, and WR_DATA waits indefinitely for payload bytes.

## Test plan
- Full write frame: with BURST_LEN=4, send 55,12,34,56,78 spaced 20 cycles. Expect four wfifo_wr_en pulses with data 12,34,56,78 in order, then wr_trig once, 1 cycle after the 4th push. rd_trig, cmd_err and frame_err stay 0.
- Read and bad opcode: send AA, then 3C. Expect rd_trig 1 cycle after AA, cmd_err 1 cycle after 3C, and no wfifo_wr_en.
- Opcodes as payload: send 55,AA,55,AA,55. Expect pushes AA,55,AA,55, then wr_trig, and no rd_trig.
- Overflow: send 55,01,02, hold wfifo_full=1, then send 03. Expect no push for 03, wfifo_clr=1 and frame_err=1 1 cycle later, and return to IDLE. A following AA gives rd_trig.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYC=100): send 55,01, then go idle. Expect wfifo_clr and frame_err exactly 100 cycles after the 01 push cycle. A repeat with a byte arriving in the expiry cycle shows no abort.
- Reset mid-frame: send 55,01, pulse s_rst for 1 cycle, then send 02. Expect all outputs 0 during reset, and 02 raises cmd_err with no push.
